// File: rtl/clint_pkg.sv
// Shared constants for the core-local interrupt controller:
// FSM state encodings, CSR addresses, instruction encodings, trap causes.
package clint_pkg;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_W_MEPC       = 3'd1,
        S_W_MSTATUS    = 3'd2,
        S_W_MCAUSE     = 3'd3,
        S_ASSERT       = 3'd4,
        S_MRET_MSTATUS = 3'd5,
        S_MRET_ASSERT  = 3'd6
    } clint_state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

    // Trap entry: MPIE <= MIE, MIE <= 0.
    function automatic logic [31:0] mstatus_trap(input logic [31:0] ms);
        return {ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
    endfunction

    // Trap return: MIE <= MPIE, MPIE <= 1.
    function automatic logic [31:0] mstatus_mret(input logic [31:0] ms);
        return {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
    endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupt controller: on ecall/ebreak, external IRQ or mret it
// holds the pipeline, writes mepc/mstatus/mcause, then issues a redirect.
// Ports:
//   clk, rst_n (sync, active-low)
//   int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i  : triggers
//   csr_mtvec_i, csr_mepc_i, csr_mstatus_i                     : CSR reads
//   csr_we_o, csr_waddr_o, csr_wdata_o                         : CSR write
//   clint_hold_flag_o, int_assert_o, int_addr_o                : pipeline
module clint
    import clint_pkg::*;
#(
    parameter int INT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [INT_W-1:0] int_flag_i,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      inst_addr_i,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic [31:0]      csr_mtvec_i,
    input  logic [31:0]      csr_mepc_i,
    input  logic [31:0]      csr_mstatus_i,
    output logic             csr_we_o,
    output logic [11:0]      csr_waddr_o,
    output logic [31:0]      csr_wdata_o,
    output logic             clint_hold_flag_o,
    output logic             int_assert_o,
    output logic [31:0]      int_addr_o
);

    clint_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  cause_q, cause_d;

    logic idle;
    logic is_ecall, is_ebreak, is_sync, is_mret, is_async;

    // Triggers only count in IDLE; gating with rst_n keeps hold low in reset.
    assign idle      = (state_q == S_IDLE) && rst_n;
    assign is_ecall  = idle && (inst_i == INST_ECALL);
    assign is_ebreak = idle && (inst_i == INST_EBREAK);
    assign is_sync   = is_ecall || is_ebreak;
    assign is_mret   = idle && !is_sync && (inst_i == INST_MRET);
    assign is_async  = idle && !is_sync && !is_mret
                     && (|int_flag_i) && csr_mstatus_i[3];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        unique case (state_q)
            S_IDLE: begin
                if (is_sync) begin
                    state_d = S_W_MEPC;
                    pc_d    = inst_addr_i;
                    cause_d = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                end else if (is_mret) begin
                    state_d = S_MRET_MSTATUS;
                end else if (is_async) begin
                    state_d = S_W_MEPC;
                    pc_d    = jump_flag_i ? jump_addr_i : inst_addr_i;
                    cause_d = CAUSE_EXT;
                end
            end
            S_W_MEPC:       state_d = S_W_MSTATUS;
            S_W_MSTATUS:    state_d = S_W_MCAUSE;
            S_W_MCAUSE:     state_d = S_ASSERT;
            S_ASSERT:       state_d = S_IDLE;
            S_MRET_MSTATUS: state_d = S_MRET_ASSERT;
            S_MRET_ASSERT:  state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        unique case (state_q)
            S_W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = pc_q;
            end
            S_W_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mstatus_trap(csr_mstatus_i);
            end
            S_W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = cause_q;
            end
            S_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mtvec_i;
            end
            S_MRET_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mstatus_mret(csr_mstatus_i);
            end
            S_MRET_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc_i;
            end
            default: ;
        endcase
    end

    assign clint_hold_flag_o = (state_q != S_IDLE)
                             || is_sync || is_mret || is_async;

endmodule
